// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, common command bytes
// and the 9-bit {parity, data} payload builder.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_XFER,
        ST_WAIT_IDLE,
        ST_ERROR
    } tx_state_e;

    localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_ACK        = 8'hFA;

    // Falling edge on which the device presents its ACK.
    localparam logic [3:0] PS2_ACK_EDGE   = 4'd11;

    // Data bits go out LSB first, followed by odd parity.
    function automatic logic [8:0] ps2_payload(input logic [7:0] data);
        return {~^data, data};
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// PS/2 line conditioner: 2-FF synchronisers on clk/data, a consecutive-sample
// glitch filter on clk, and a one-cycle strobe on each filtered falling edge.
module ps2_host_tx_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_raw,
    input  logic data_raw,
    output logic clk_filt,
    output logic data_sync,
    output logic clk_fall
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
    logic          filt_q, filt_d, fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        clk_meta_d  = clk_raw;
        clk_sync_d  = clk_meta_q;
        data_meta_d = data_raw;
        data_sync_d = data_meta_q;
        filt_d      = filt_q;
        cnt_d       = '0;
        // Count consecutive samples disagreeing with the accepted level;
        // any agreeing sample restarts the count, so short glitches vanish.
        if (clk_sync_q != filt_q) begin
            if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_meta_q  <= clk_meta_d;
            clk_sync_q  <= clk_sync_d;
            data_meta_q <= data_meta_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    assign clk_filt  = filt_q;
    assign data_sync = data_sync_q;
    assign clk_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, then shift
// the frame out on device-generated clock falls and check the device ACK.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 2400,
    parameter int TIMEOUT_CYCLES = 331000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_drive_low,
    output logic       ps2_data_drive_low
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    edge_q, edge_d;
    logic [8:0]    shift_q, shift_d;
    logic          data_low_q, data_low_d;
    logic          clk_filt, data_sync, clk_fall;
    logic          timed_out;

    ps2_host_tx_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_raw   (ps2_clk_in),
        .data_raw  (ps2_data_in),
        .clk_filt  (clk_filt),
        .data_sync (data_sync),
        .clk_fall  (clk_fall)
    );

    assign timed_out = (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
        edge_d     = edge_q;
        shift_d    = shift_q;
        data_low_d = data_low_q;
        tx_done    = 1'b0;
        tx_error   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                edge_d     = '0;
                data_low_d = 1'b0;
                if (tx_valid) begin
                    shift_d = ps2_payload(tx_data);
                    state_d = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q >= CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                // Start bit stays driven low through XFER until the first fall.
                data_low_d = 1'b1;
                cnt_d      = '0;
                edge_d     = '0;
                state_d    = ST_XFER;
            end
            ST_XFER: begin
                if (clk_fall) begin
                    cnt_d  = '0;
                    edge_d = (edge_q == PS2_ACK_EDGE) ? edge_q : edge_q + 1'b1;
                    if (edge_q < 4'd9) begin
                        data_low_d = ~shift_q[0];
                        shift_d    = {1'b0, shift_q[8:1]};
                    end else if (edge_q == 4'd9) begin
                        data_low_d = 1'b0;
                    end else begin
                        data_low_d = 1'b0;
                        state_d    = data_sync ? ST_ERROR : ST_WAIT_IDLE;
                    end
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_filt && data_sync) begin
                    tx_done = 1'b1;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    state_d = ST_ERROR;
                end
            end
            ST_ERROR: begin
                tx_error   = 1'b1;
                data_low_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            shift_q    <= '0;
            data_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            shift_q    <= shift_d;
            data_low_q <= data_low_d;
        end
    end

    assign tx_ready           = (state_q == ST_IDLE);
    assign rx_inhibit         = (state_q != ST_IDLE);
    assign ps2_clk_drive_low  = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
    assign ps2_data_drive_low = (state_q == ST_RTS) || ((state_q == ST_XFER) && data_low_q);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed + random bench for ps2_host_tx with a clock-generating keyboard model
// on open-drain lines; frames are checked against an arithmetic frame model.
module tb_ps2_host_tx;

    localparam int INHIBIT = 60;
    localparam int TIMEOUT = 2000;
    localparam int FLEN    = 8;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_error, rx_inhibit;
    logic       ps2_clk_drive_low, ps2_data_drive_low;
    logic       bfm_clk_low = 1'b0;
    logic       bfm_data_low = 1'b0;
    wire        ps2_clk_line  = ~(ps2_clk_drive_low | bfm_clk_low);
    wire        ps2_data_line = ~(ps2_data_drive_low | bfm_data_low);

    int ncmp = 0;
    int nerr = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int run_len = 0, inh_len = 0;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT),
        .FILTER_LEN     (FLEN)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .tx_done            (tx_done),
        .tx_error           (tx_error),
        .rx_inhibit         (rx_inhibit),
        .ps2_clk_in         (ps2_clk_line),
        .ps2_data_in        (ps2_data_line),
        .ps2_clk_drive_low  (ps2_clk_drive_low),
        .ps2_data_drive_low (ps2_data_drive_low)
    );

    // Pulse counters and inhibit-length measurement (clk low before data low).
    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_error) err_cnt++;
        if (tx_done && tx_error) both_cnt++;
        if (ps2_clk_drive_low && !ps2_data_drive_low) begin
            run_len++;
        end else begin
            if (ps2_clk_drive_low && ps2_data_drive_low) inh_len = run_len;
            run_len = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = (b / (8'd1 << i)) % 2;
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input string tag);
        int k;
        k = 0;
        while (!tx_ready && k < 3000) begin @(negedge clk); k++; end
        chk({tag, "_ready"}, tx_ready, 1'b1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk({tag, "_ready_drop"}, tx_ready, 1'b0);
        // A request while busy must be ignored, not queued or captured.
        tx_data  = ~b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic bfm_xfer(input bit ack, input bit glitch, input int stop_at,
                            output logic [10:0] frame, output bit ok);
        int k;
        ok    = 1'b0;
        frame = '0;
        k     = 0;
        while (!(ps2_data_line == 1'b0 && ps2_clk_line == 1'b1) && k < 1000) begin
            @(negedge clk); k++;
        end
        if (k >= 1000) return;
        ok       = 1'b1;
        frame[0] = ps2_data_line;
        repeat (HALF) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) bfm_data_low = 1'b1;
            bfm_clk_low = 1'b1;
            if (i == stop_at) begin
                repeat (20) @(negedge clk);
                return;
            end
            repeat (HALF) @(negedge clk);
            if (i <= 10) frame[i] = ps2_data_line;
            bfm_clk_low = 1'b0;
            if (glitch && i < 10) begin
                repeat (15) @(negedge clk);
                bfm_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                bfm_clk_low = 1'b0;
                repeat (HALF - 18) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            bfm_data_low = 1'b0;
        end
    endtask

    task automatic run_xfer(input logic [7:0] b, input bit ack, input bit glitch, input string tag);
        logic [10:0] frame;
        bit ok;
        int d0, e0, k;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(b, tag);
        bfm_xfer(ack, glitch, 0, frame, ok);
        chk({tag, "_rts_seen"}, ok, 1'b1);
        chk({tag, "_frame"}, frame, model_frame(b));
        k = 0;
        while (!(tx_ready && (done_cnt != d0 || err_cnt != e0)) && k < 500) begin
            @(negedge clk); k++;
        end
        repeat (5) @(negedge clk);
        chk({tag, "_done_pulses"}, done_cnt - d0, ack ? 1 : 0);
        chk({tag, "_error_pulses"}, err_cnt - e0, ack ? 0 : 1);
        chk({tag, "_pins_released"}, {ps2_clk_drive_low, ps2_data_drive_low}, 2'b00);
    endtask

    initial begin
        logic [10:0] frame;
        bit ok;
        int k;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_outputs",
            {tx_ready, tx_done, tx_error, rx_inhibit, ps2_clk_drive_low, ps2_data_drive_low},
            6'b100000);

        // 1: LED command with ACK
        run_xfer(8'hED, 1'b1, 1'b0, "led_cmd");

        // 2: enable command; inhibit hold measured before start bit
        run_xfer(8'hF4, 1'b1, 1'b0, "enable_cmd");
        chk("inhibit_len", inh_len, INHIBIT);

        // 3: silent device -> timeout counted from XFER entry
        send_byte(8'hA5, "timeout");
        k = 0;
        while (!ps2_data_drive_low && k < 500) begin @(negedge clk); k++; end
        chk("timeout_rts_seen", ps2_data_drive_low, 1'b1);
        @(negedge clk);
        chk("timeout_clk_released", ps2_clk_drive_low, 1'b0);
        k = 0;
        while (!tx_error && k < TIMEOUT + 100) begin @(negedge clk); k++; end
        chk("timeout_latency", k, TIMEOUT);
        @(negedge clk);
        chk("timeout_idle", {tx_ready, rx_inhibit, ps2_clk_drive_low, ps2_data_drive_low}, 4'b1000);

        // 4: missing ACK
        run_xfer(8'h3C, 1'b0, 1'b0, "no_ack");

        // 5: glitches on ps2_clk during the transfer
        run_xfer(8'h96, 1'b1, 1'b1, "glitch");

        // 6: reset mid-transfer, then a full reset command
        send_byte(8'h55, "midreset");
        bfm_xfer(1'b1, 1'b0, 5, frame, ok);
        chk("midreset_rts_seen", ok, 1'b1);
        chk("midreset_busy", rx_inhibit, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("midreset_released",
            {tx_ready, rx_inhibit, ps2_clk_drive_low, ps2_data_drive_low}, 4'b1000);
        bfm_clk_low  = 1'b0;
        bfm_data_low = 1'b0;
        repeat (30) @(negedge clk);
        run_xfer(8'hFF, 1'b1, 1'b0, "reset_cmd");

        // Random bytes, random glitching
        for (int r = 0; r < 4; r++) begin
            run_xfer(8'($urandom_range(0, 255)), 1'b1, 1'($urandom_range(0, 1)),
                     $sformatf("rand%0d", r));
        end

        chk("done_error_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
